jtvigil_snd_ctrl: RTL and testbench
===================================

JTVIGIL_SND_CTRL -- requirements
Module: jtvigil_snd_ctrl

Interface
REQ-001 Parameter: SMP_AW, default 16, sample ROM address width.
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cen  in  1  sound CPU clock enable; CPU-side strobes are sampled only when high.
REQ-005 latch_cs  in  1  main CPU sound-latch write strobe; may stay high for several clk cycles.
REQ-006 main_dout  in  8  main CPU data bus.
REQ-007 io_addr  in  8  sound CPU I/O address A[7:0].
REQ-008 io_wr, io_rd  in  1 each  sound CPU I/O write/read strobes, combinational from iorq_n/wr_n/rd_n.
REQ-009 int_ack  in  1  sound CPU interrupt acknowledge (iorq_n and m1_n both low).
REQ-010 snd_dout  in  8  sound CPU data bus.
REQ-011 ym_irq_n  in  1  YM2151 interrupt, active low.
REQ-012 snd_int_n  out  1  sound CPU INT, active low.
REQ-013 io_din  out  8  data to sound CPU (latch, sample or IRQ vector).
REQ-014 wait_n  out  1  sound CPU wait request, active low.
REQ-015 smp_addr  out  SMP_AW  sample ROM address.
REQ-016 smp_cs  out  1  sample ROM request.
REQ-017 smp_data  in  8  sample ROM data.
REQ-018 smp_ok  in  1  sample ROM data valid.
REQ-019 dac  out  8  unsigned DAC sample.

Function
REQ-020 latch_cs rising edge (clk-domain edge detect) SHALL store main_dout in snd_latch and set latch_irq; a held strobe SHALL cause exactly one capture.
REQ-021 io_wr at 0x83 SHALL clear latch_irq; a capture and a clear in the same cycle SHALL leave latch_irq set.
REQ-022 snd_int_n SHALL equal ~(latch_irq | ~ym_irq_n), registered, 1-cycle latency.
REQ-023 On int_ack, io_din SHALL be the vector 8'hFF with bit5 cleared if latch_irq and bit4 cleared if ym_irq_n low (0xDF, 0xEF, 0xCF); int_ack takes priority over io_rd.
REQ-024 io_rd at 0x02 SHALL return snd_latch; reads SHALL NOT clear latch_irq.
REQ-025 io_wr at 0x80 / 0x81 SHALL load smp_addr[7:0] / smp_addr[15:8] and start a fetch.
REQ-026 io_wr at 0x82 SHALL load dac with snd_dout, increment smp_addr modulo 2^SMP_AW (0xFFFF -> 0x0000) and start a fetch.
REQ-027 Fetch FSM states: IDLE, FETCH, READY; IDLE/READY->FETCH on address change; FETCH->READY when smp_ok is seen high with smp_cs high, capturing smp_data in smp_buf.
REQ-028 smp_cs SHALL be high only in FETCH; smp_addr SHALL be stable while smp_cs is high, except a new address write, which restarts FETCH at the new address and discards the in-flight result.
REQ-029 smp_ok one cycle after the address changed SHALL NOT be accepted (one-cycle settle after each FETCH entry).
REQ-030 io_rd at 0x84 in READY SHALL return smp_buf; in IDLE or FETCH wait_n SHALL be low until READY, then the read completes with the fresh byte.
REQ-031 Unmapped io_rd SHALL return 0xFF; unmapped io_wr SHALL be ignored.

Reset
REQ-032 During rst: snd_latch=0, latch_irq=0, snd_int_n=1, smp_addr=0, dac=8'h80, smp_buf=0, FSM=IDLE, smp_cs=0, wait_n=1, io_din=0xFF.
REQ-033 Reset asserted mid-FETCH SHALL drop smp_cs the next cycle, and a late smp_ok SHALL be ignored.
REQ-034 After rst releases, a latch_cs already high SHALL NOT be captured until it falls and rises again.

Structure
REQ-035 Shared package jtvigil_pkg SHALL hold the I/O port constants (0x02, 0x80-0x84), the vector bit positions (5, 4) and the FSM state encoding.
REQ-036 Single module, no sub-modules; the fetch FSM is inline; target 150-250 RTL lines.

Verification
REQ-037 latch_cs held 3 cycles with main_dout=0x5A -> one capture, snd_int_n low, int_ack gives 0xDF, port 0x02 reads 0x5A; write 0x83 -> snd_int_n high.
REQ-038 ym_irq_n low plus a pending latch -> vector 0xCF; write 0x83 -> vector 0xEF, snd_int_n stays low.
REQ-039 Write 0x34 to 0x80 and 0x12 to 0x81, smp_ok after 4 cycles with data 0xA7 -> smp_addr=0x1234, read 0x84 returns 0xA7, wait_n low only before READY.
REQ-040 smp_addr=0xFFFF, write 0x40 to 0x82 -> dac=0x40, smp_addr=0x0000, new fetch issued.
REQ-041 Write to 0x81 during FETCH with a stale smp_ok the same cycle -> stale data discarded, refetch at new address.
REQ-042 rst pulse mid-FETCH -> smp_cs=0 next cycle, FSM=IDLE, dac=0x80, a later smp_ok is ignored.

Source files
------------

// File: rtl/jtvigil_pkg.sv
// Shared constants for the Vigilante sound controller: I/O port map,
// interrupt vector bit positions and the sample fetch state encoding.
package jtvigil_pkg;

  // Sound CPU I/O ports
  localparam logic [7:0] PORT_LATCH   = 8'h02;
  localparam logic [7:0] PORT_ADDR_LO = 8'h80;
  localparam logic [7:0] PORT_ADDR_HI = 8'h81;
  localparam logic [7:0] PORT_DAC     = 8'h82;
  localparam logic [7:0] PORT_IRQ_ACK = 8'h83;
  localparam logic [7:0] PORT_SMP     = 8'h84;

  // Bits cleared in the 0xFF interrupt vector for each pending source
  localparam int VEC_LATCH_BIT = 5;
  localparam int VEC_YM_BIT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } fetch_state_t;

  // Interrupt vector: 0xFF with one bit pulled low per pending source
  function automatic logic [7:0] irq_vector(input logic latch_irq, input logic ym_irq_n);
    logic [7:0] v;
    v = 8'hFF;
    v[VEC_LATCH_BIT] = ~latch_irq;
    v[VEC_YM_BIT]    = ym_irq_n;
    return v;
  endfunction

endpackage

// File: rtl/jtvigil_snd_ctrl.sv
// Vigilante sound CPU glue: main-CPU sound latch with interrupt, interrupt
// vector generation, sample ROM address/fetch logic and the DAC register.
// The sample address is written as two bytes, so SMP_AW must be at least 16.
module jtvigil_snd_ctrl
  import jtvigil_pkg::*;
#(
  parameter int SMP_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              latch_cs,
  input  logic [7:0]        main_dout,
  input  logic [7:0]        io_addr,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic              int_ack,
  input  logic [7:0]        snd_dout,
  input  logic              ym_irq_n,
  output logic              snd_int_n,
  output logic [7:0]        io_din,
  output logic              wait_n,
  output logic [SMP_AW-1:0] smp_addr,
  output logic              smp_cs,
  input  logic [7:0]        smp_data,
  input  logic              smp_ok,
  output logic [7:0]        dac
);

  logic         latch_cs_l;
  logic         latch_rise;
  logic [7:0]   snd_latch;
  logic         latch_irq;
  logic [7:0]   smp_buf;
  logic         settle;
  logic         wr_en;
  logic         addr_wr;
  logic         irq_clr;
  logic         accept;
  fetch_state_t state, state_nxt;

  // Register writes only happen on sound CPU clock-enable cycles; reads and
  // the vector are combinational so the CPU sees data for the whole cycle.
  assign wr_en      = cen & io_wr;
  assign addr_wr    = wr_en & ((io_addr == PORT_ADDR_LO) | (io_addr == PORT_ADDR_HI) |
                               (io_addr == PORT_DAC));
  assign irq_clr    = wr_en & (io_addr == PORT_IRQ_ACK);
  assign latch_rise = latch_cs & ~latch_cs_l;
  // The first FETCH cycle is a settle cycle: ROM data there belongs to the old address
  assign accept     = (state == ST_FETCH) & smp_ok & ~settle;

  // Previous latch strobe, tracked through reset so a strobe held across reset is not captured
  always_ff @(posedge clk) begin
    latch_cs_l <= latch_cs;
  end

  // Sound latch capture and its interrupt flag; a capture wins over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      snd_latch <= 8'h00;
      latch_irq <= 1'b0;
    end else if (latch_rise) begin
      snd_latch <= main_dout;
      latch_irq <= 1'b1;
    end else if (irq_clr) begin
      latch_irq <= 1'b0;
    end
  end

  // Registered interrupt line combining the latch and YM2151 sources
  always_ff @(posedge clk) begin
    if (rst) snd_int_n <= 1'b1;
    else     snd_int_n <= ~(latch_irq | ~ym_irq_n);
  end

  // Sample address byte loads, DAC load with address post-increment
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_addr <= '0;
      dac      <= 8'h80;
    end else if (wr_en) begin
      case (io_addr)
        PORT_ADDR_LO: smp_addr[7:0]  <= snd_dout;
        PORT_ADDR_HI: smp_addr[15:8] <= snd_dout;
        PORT_DAC: begin
          dac      <= snd_dout;
          smp_addr <= smp_addr + SMP_AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Fetch state register plus the settle flag marking the first FETCH cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      settle <= 1'b0;
    end else begin
      state  <= state_nxt;
      settle <= addr_wr;
    end
  end

  // Fetch next state; any address change restarts the fetch and drops in-flight data
  always_comb begin
    state_nxt = state;
    smp_cs    = (state == ST_FETCH);
    if (addr_wr) begin
      state_nxt = ST_FETCH;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_FETCH: if (accept) state_nxt = ST_READY;
        ST_READY: state_nxt = ST_READY;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sample byte buffer, loaded only from an accepted, non-superseded fetch
  always_ff @(posedge clk) begin
    if (rst)                     smp_buf <= 8'h00;
    else if (accept && !addr_wr) smp_buf <= smp_data;
  end

  // Read data mux; the interrupt vector takes priority over port reads
  always_comb begin
    io_din = 8'hFF;
    if (!rst) begin
      if (int_ack) begin
        io_din = irq_vector(latch_irq, ym_irq_n);
      end else if (io_rd) begin
        case (io_addr)
          PORT_LATCH: io_din = snd_latch;
          PORT_SMP:   io_din = smp_buf;
          default:    io_din = 8'hFF;
        endcase
      end
    end
  end

  // Stall a sample read until a fetched byte is available
  assign wait_n = rst | ~(io_rd & ~int_ack & (io_addr == PORT_SMP) & (state != ST_READY));

endmodule

// File: tb/tb_jtvigil_snd_ctrl.sv
// Self-checking bench for jtvigil_snd_ctrl: a behavioural model is compared
// against every output on every cycle, plus hand-computed spot checks.
module tb_jtvigil_snd_ctrl;

  logic        clk = 1'b0;
  logic        rst, cen, latch_cs, io_wr, io_rd, int_ack, ym_irq_n, smp_ok;
  logic [7:0]  main_dout, io_addr, snd_dout, smp_data;
  logic        snd_int_n, wait_n, smp_cs;
  logic [7:0]  io_din, dac;
  logic [15:0] smp_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [7:0]  m_latch, m_dac, m_buf;
  logic        m_irq, m_int_n, m_busy, m_ready, m_prev_cs;
  logic [15:0] m_addr;
  int          m_age;

  always #5 clk = ~clk;

  jtvigil_snd_ctrl #(.SMP_AW(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .latch_cs(latch_cs), .main_dout(main_dout),
    .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .int_ack(int_ack),
    .snd_dout(snd_dout), .ym_irq_n(ym_irq_n), .snd_int_n(snd_int_n),
    .io_din(io_din), .wait_n(wait_n), .smp_addr(smp_addr), .smp_cs(smp_cs),
    .smp_data(smp_data), .smp_ok(smp_ok), .dac(dac)
  );

  // Model: latch/irq bookkeeping, address/DAC writes, and a fetch that
  // completes on the first smp_ok at least one cycle after the address changed
  always @(posedge clk) begin : model_proc
    logic wr;
    if (rst) begin
      m_latch = 8'h00; m_irq = 1'b0; m_int_n = 1'b1; m_addr = 16'h0000;
      m_dac = 8'h80; m_buf = 8'h00; m_busy = 1'b0; m_ready = 1'b0; m_age = 0;
    end else begin
      m_int_n = !(m_irq || !ym_irq_n);
      wr = cen && io_wr;
      if (latch_cs && !m_prev_cs) begin
        m_latch = main_dout;
        m_irq   = 1'b1;
      end else if (wr && io_addr == 8'h83) begin
        m_irq = 1'b0;
      end
      if (wr && (io_addr inside {8'h80, 8'h81, 8'h82})) begin
        if (io_addr == 8'h80) m_addr[7:0] = snd_dout;
        if (io_addr == 8'h81) m_addr[15:8] = snd_dout;
        if (io_addr == 8'h82) begin
          m_dac  = snd_dout;
          m_addr = m_addr + 16'd1;
        end
        m_busy = 1'b1; m_ready = 1'b0; m_age = 0;
      end else if (m_busy) begin
        if (smp_ok && m_age >= 1) begin
          m_buf = smp_data; m_busy = 1'b0; m_ready = 1'b1;
        end else begin
          m_age++;
        end
      end
    end
    m_prev_cs = latch_cs;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Compare all outputs with the model and the current inputs
  task automatic checkModel();
    logic [7:0] ed;
    logic       ew;
    ed = 8'hFF;
    ew = 1'b1;
    if (!rst) begin
      if (int_ack) begin
        if (m_irq)     ed = ed & 8'hDF;
        if (!ym_irq_n) ed = ed & 8'hEF;
      end else if (io_rd) begin
        if (io_addr == 8'h02) ed = m_latch;
        else if (io_addr == 8'h84) begin
          ed = m_buf;
          ew = m_ready;
        end
      end
    end
    checkOutput("cyc_smp_cs",    16'(smp_cs),    16'(m_busy));
    checkOutput("cyc_smp_addr",  smp_addr,       m_addr);
    checkOutput("cyc_dac",       16'(dac),       16'(m_dac));
    checkOutput("cyc_snd_int_n", 16'(snd_int_n), 16'(m_int_n));
    checkOutput("cyc_io_din",    16'(io_din),    16'(ed));
    checkOutput("cyc_wait_n",    16'(wait_n),    16'(ew));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      checkModel();
    end
  endtask

  task automatic ioWrite(input logic [7:0] a, input logic [7:0] d);
    io_addr = a;
    snd_dout = d;
    io_wr = 1'b1;
    applyStimulus(1);
    io_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; latch_cs = 1'b1; main_dout = 8'h11;
    io_addr = 8'h84; io_wr = 1'b0; io_rd = 1'b1; int_ack = 1'b0;
    snd_dout = 8'h00; ym_irq_n = 1'b1; smp_data = 8'h99; smp_ok = 1'b0;

    // Reset values, with a sample read pending and latch_cs held high
    applyStimulus(2);
    checkOutput("rst_dac",      16'(dac),       16'h80);
    checkOutput("rst_int_n",    16'(snd_int_n), 16'h1);
    checkOutput("rst_smp_cs",   16'(smp_cs),    16'h0);
    checkOutput("rst_smp_addr", smp_addr,       16'h0000);
    checkOutput("rst_io_din",   16'(io_din),    16'hFF);
    checkOutput("rst_wait_n",   16'(wait_n),    16'h1);

    // latch_cs held across reset release is not captured
    rst = 1'b0; io_rd = 1'b0;
    applyStimulus(2);
    checkOutput("held_cs_no_capture", 16'(snd_int_n), 16'h1);
    io_rd = 1'b1; io_addr = 8'h02;
    applyStimulus(1);
    checkOutput("latch_after_rst", 16'(io_din), 16'h00);
    io_rd = 1'b0;
    latch_cs = 1'b0;
    applyStimulus(1);

    // Held strobe: one capture of 0x5A
    main_dout = 8'h5A; latch_cs = 1'b1;
    applyStimulus(3);
    latch_cs = 1'b0;
    checkOutput("latch_int_n", 16'(snd_int_n), 16'h0);
    int_ack = 1'b1;
    applyStimulus(1);
    checkOutput("vec_latch", 16'(io_din), 16'hDF);
    int_ack = 1'b0; io_rd = 1'b1; io_addr = 8'h02;
    applyStimulus(1);
    checkOutput("read_latch", 16'(io_din), 16'h5A);
    io_rd = 1'b0;
    applyStimulus(1);
    checkOutput("read_keeps_irq", 16'(snd_int_n), 16'h0);
    ioWrite(8'h83, 8'h00);
    applyStimulus(1);
    checkOutput("ack_clears", 16'(snd_int_n), 16'h1);

    // Capture and clear in the same cycle leaves the interrupt pending
    main_dout = 8'hC3; latch_cs = 1'b1;
    ioWrite(8'h83, 8'h00);
    latch_cs = 1'b0;
    applyStimulus(1);
    checkOutput("capture_beats_clear", 16'(snd_int_n), 16'h0);

    // YM interrupt together with the latch, then alone
    ym_irq_n = 1'b0; int_ack = 1'b1;
    applyStimulus(1);
    checkOutput("vec_both", 16'(io_din), 16'hCF);
    int_ack = 1'b0;
    ioWrite(8'h83, 8'h00);
    int_ack = 1'b1;
    applyStimulus(1);
    checkOutput("vec_ym", 16'(io_din), 16'hEF);
    checkOutput("ym_holds_int", 16'(snd_int_n), 16'h0);
    int_ack = 1'b0; ym_irq_n = 1'b1;
    applyStimulus(2);
    checkOutput("int_released", 16'(snd_int_n), 16'h1);

    // Unmapped accesses
    io_rd = 1'b1; io_addr = 8'h10;
    applyStimulus(1);
    checkOutput("unmapped_read", 16'(io_din), 16'hFF);
    io_rd = 1'b0;
    ioWrite(8'h90, 8'h12);
    applyStimulus(1);
    checkOutput("unmapped_write_dac", 16'(dac), 16'h80);
    checkOutput("unmapped_write_no_fetch", 16'(smp_cs), 16'h0);

    // Sample fetch at 0x1234, read stalls until the byte arrives
    ioWrite(8'h80, 8'h34);
    ioWrite(8'h81, 8'h12);
    io_rd = 1'b1; io_addr = 8'h84;
    applyStimulus(1);
    checkOutput("wait_in_fetch", 16'(wait_n), 16'h0);
    checkOutput("addr_1234", smp_addr, 16'h1234);
    checkOutput("cs_in_fetch", 16'(smp_cs), 16'h1);
    applyStimulus(1);
    smp_ok = 1'b1; smp_data = 8'hA7;
    applyStimulus(1);
    smp_ok = 1'b0; smp_data = 8'h99;
    checkOutput("wait_released", 16'(wait_n), 16'h1);
    checkOutput("smp_read", 16'(io_din), 16'hA7);
    checkOutput("cs_dropped_ready", 16'(smp_cs), 16'h0);
    io_rd = 1'b0;

    // smp_ok in the settle cycle is ignored
    smp_ok = 1'b1; smp_data = 8'h11;
    ioWrite(8'h80, 8'h56);
    applyStimulus(1);
    smp_ok = 1'b0;
    applyStimulus(1);
    smp_ok = 1'b1; smp_data = 8'h22;
    applyStimulus(1);
    smp_ok = 1'b0;
    io_rd = 1'b1; io_addr = 8'h84;
    applyStimulus(1);
    checkOutput("settle_ignored", 16'(io_din), 16'h22);
    io_rd = 1'b0;

    // Address write during FETCH with a stale smp_ok: refetch, old data dropped
    ioWrite(8'h80, 8'h00);
    applyStimulus(1);
    smp_ok = 1'b1; smp_data = 8'hEE;
    ioWrite(8'h81, 8'h77);
    smp_ok = 1'b0;
    checkOutput("refetch_cs", 16'(smp_cs), 16'h1);
    checkOutput("refetch_addr", smp_addr, 16'h7700);
    io_rd = 1'b1; io_addr = 8'h84;
    applyStimulus(1);
    checkOutput("stale_not_loaded", 16'(io_din), 16'h22);
    checkOutput("stale_wait", 16'(wait_n), 16'h0);
    smp_ok = 1'b1; smp_data = 8'h3C;
    applyStimulus(1);
    smp_ok = 1'b0;
    checkOutput("refetch_data", 16'(io_din), 16'h3C);
    io_rd = 1'b0;

    // Writes ignored without cen; DAC write wraps the address
    ioWrite(8'h80, 8'hFF);
    ioWrite(8'h81, 8'hFF);
    checkOutput("addr_ffff", smp_addr, 16'hFFFF);
    cen = 1'b0;
    ioWrite(8'h82, 8'h99);
    cen = 1'b1;
    checkOutput("cen_gates_dac", 16'(dac), 16'h80);
    checkOutput("cen_gates_addr", smp_addr, 16'hFFFF);
    ioWrite(8'h82, 8'h40);
    checkOutput("dac_load", 16'(dac), 16'h40);
    checkOutput("addr_wrap", smp_addr, 16'h0000);
    checkOutput("wrap_fetch", 16'(smp_cs), 16'h1);

    // Reset mid-FETCH, then a late smp_ok is ignored
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_drops_cs", 16'(smp_cs), 16'h0);
    checkOutput("rst_dac_mid", 16'(dac), 16'h80);
    rst = 1'b0; smp_ok = 1'b1; smp_data = 8'h55;
    applyStimulus(1);
    smp_ok = 1'b0;
    io_rd = 1'b1; io_addr = 8'h84;
    applyStimulus(1);
    checkOutput("late_ok_wait", 16'(wait_n), 16'h0);
    checkOutput("late_ok_cs", 16'(smp_cs), 16'h0);
    checkOutput("late_ok_buf", 16'(io_din), 16'h00);
    io_rd = 1'b0;
    applyStimulus(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
